// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command path: opcodes, sequencer states, data width.
package alu_pkg;

    localparam int DATA_W = 16;

    localparam logic [3:0] OP_A_INC   = 4'h0;
    localparam logic [3:0] OP_A_DEC   = 4'h1;
    localparam logic [3:0] OP_ADD     = 4'h2;
    localparam logic [3:0] OP_SUB     = 4'h3;
    localparam logic [3:0] OP_B_SUB_A = 4'h4;
    localparam logic [3:0] OP_MUL     = 4'h5;
    localparam logic [3:0] OP_DIV     = 4'h6;
    localparam logic [3:0] OP_MOD     = 4'h7;
    localparam logic [3:0] OP_AND     = 4'h8;
    localparam logic [3:0] OP_OR      = 4'h9;
    localparam logic [3:0] OP_NOT_A   = 4'hA;
    localparam logic [3:0] OP_NOT_B   = 4'hB;
    localparam logic [3:0] OP_NAND    = 4'hC;
    localparam logic [3:0] OP_NOR     = 4'hD;
    localparam logic [3:0] OP_XOR     = 4'hE;
    localparam logic [3:0] OP_XNOR    = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } seq_state_t;

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

    // Opcodes 8..F are bitwise; their carry has no meaning.
    function automatic logic is_logic_op(input logic [3:0] op);
        return op[3];
    endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Sequences one command at a time into the combinational ALU, holds the inputs for a
// programmable settle time, captures the result and returns it with status flags.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              Clock_In,
    input  logic              Reset_In,
    input  logic              Cmd_Valid_In,
    output logic              Cmd_Ready_Out,
    input  logic [3:0]        Cmd_Op_In,
    input  logic              Cmd_Use_Acc_In,
    input  logic [DATA_W-1:0] Cmd_A_In,
    input  logic [DATA_W-1:0] Cmd_B_In,
    output logic              ALU_Enable_Out,
    output logic [3:0]        ALU_Op_Out,
    output logic [DATA_W-1:0] ALU_A_Out,
    output logic [DATA_W-1:0] ALU_B_Out,
    input  logic [DATA_W-1:0] ALU_Result_In,
    input  logic              ALU_Carry_In,
    output logic              Rsp_Valid_Out,
    input  logic              Rsp_Ready_In,
    output logic [DATA_W-1:0] Rsp_Result_Out,
    output logic              Rsp_Carry_Out,
    output logic              Rsp_Zero_Out,
    output logic              Rsp_Div_Zero_Out
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    seq_state_t        state;
    logic [3:0]        settle_cnt;
    logic [DATA_W-1:0] acc;
    logic [3:0]        op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              enable_q;

    assign Cmd_Ready_Out  = (state == ST_IDLE);
    assign Rsp_Valid_Out  = (state == ST_RESP);
    assign ALU_Enable_Out = enable_q;
    assign ALU_Op_Out     = op_q;
    assign ALU_A_Out      = a_q;
    assign ALU_B_Out      = b_q;

    // The first DRIVE cycle only presents operands (enable still low); a division by
    // zero leaves from there straight to RESP, so the ALU is never enabled for it.
    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            state            <= ST_IDLE;
            settle_cnt       <= '0;
            acc              <= '0;
            op_q             <= '0;
            a_q              <= '0;
            b_q              <= '0;
            enable_q         <= 1'b0;
            Rsp_Result_Out   <= '0;
            Rsp_Carry_Out    <= 1'b0;
            Rsp_Zero_Out     <= 1'b1;
            Rsp_Div_Zero_Out <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Cmd_Valid_In) begin
                        op_q       <= Cmd_Op_In;
                        a_q        <= Cmd_Use_Acc_In ? acc : Cmd_A_In;
                        b_q        <= Cmd_B_In;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (!enable_q) begin
                        if (is_div_op(op_q) && (b_q == '0)) begin
                            Rsp_Result_Out   <= '0;
                            Rsp_Carry_Out    <= 1'b0;
                            Rsp_Zero_Out     <= 1'b1;
                            Rsp_Div_Zero_Out <= 1'b1;
                            state            <= ST_RESP;
                        end else begin
                            enable_q <= 1'b1;
                        end
                    end else if (settle_cnt == 4'd0) begin
                        enable_q         <= 1'b0;
                        Rsp_Result_Out   <= ALU_Result_In;
                        Rsp_Carry_Out    <= ALU_Carry_In & ~is_logic_op(op_q);
                        Rsp_Zero_Out     <= (ALU_Result_In == '0);
                        Rsp_Div_Zero_Out <= 1'b0;
                        acc              <= ALU_Result_In;
                        state            <= ST_RESP;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (Rsp_Ready_In) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Drives two sequencers (settle 1 and settle 4) against a behavioural ALU and a
// command-level reference model of results, flags, accumulator and timing.
module tb_alu_op_sequencer;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    logic        cmd_valid   [2];
    logic [3:0]  cmd_op      [2];
    logic        cmd_use_acc [2];
    logic [15:0] cmd_a       [2];
    logic [15:0] cmd_b       [2];
    logic        rsp_ready   [2];
    logic        cmd_ready   [2];
    logic        alu_en      [2];
    logic [3:0]  alu_op      [2];
    logic [15:0] alu_a       [2];
    logic [15:0] alu_b       [2];
    logic [15:0] alu_result  [2];
    logic        alu_carry   [2];
    logic        rsp_valid   [2];
    logic [15:0] rsp_result  [2];
    logic        rsp_carry   [2];
    logic        rsp_zero    [2];
    logic        rsp_dz      [2];

    logic [15:0] acc_model [2];
    int checkCount = 0;
    int errorCount = 0;

    // Full 17-bit ALU result using plain unsigned arithmetic.
    function automatic logic [16:0] alu_full(input logic [3:0] op, input logic [15:0] a,
                                             input logic [15:0] b);
        logic [31:0] a32, b32, r;
        logic [15:0] l;
        a32 = {16'h0, a};
        b32 = {16'h0, b};
        l   = 16'h0;
        r   = 32'h0;
        case (op)
            4'h0: r = a32 + 32'd1;
            4'h1: r = a32 - 32'd1;
            4'h2: r = a32 + b32;
            4'h3: r = a32 - b32;
            4'h4: r = b32 - a32;
            4'h5: r = a32 * b32;
            4'h6: r = (b == 16'h0) ? 32'h0 : a32 / b32;
            4'h7: r = (b == 16'h0) ? 32'h0 : a32 % b32;
            default: begin
                case (op)
                    4'h8: l = a & b;
                    4'h9: l = a | b;
                    4'hA: l = ~a;
                    4'hB: l = ~b;
                    4'hC: l = ~(a & b);
                    4'hD: l = ~(a | b);
                    4'hE: l = a ^ b;
                    default: l = ~(a ^ b);
                endcase
                r = {16'h0, l};
            end
        endcase
        return r[16:0];
    endfunction

    function automatic int settle_of(input int idx);
        return (idx == 0) ? 1 : 4;
    endfunction

    // Environment ALU: garbage while disabled, spurious carry on bitwise ops.
    for (genvar g = 0; g < 2; g++) begin : g_alu
        logic [16:0] full;
        assign full          = alu_full(alu_op[g], alu_a[g], alu_b[g]);
        assign alu_result[g] = alu_en[g] ? full[15:0] : 16'hDEAD;
        assign alu_carry[g]  = alu_en[g] & (alu_op[g][3] | full[16]);
    end

    alu_op_sequencer #(.SETTLE_CYCLES(1)) dut_s1 (
        .Clock_In(clock), .Reset_In(reset),
        .Cmd_Valid_In(cmd_valid[0]), .Cmd_Ready_Out(cmd_ready[0]), .Cmd_Op_In(cmd_op[0]),
        .Cmd_Use_Acc_In(cmd_use_acc[0]), .Cmd_A_In(cmd_a[0]), .Cmd_B_In(cmd_b[0]),
        .ALU_Enable_Out(alu_en[0]), .ALU_Op_Out(alu_op[0]), .ALU_A_Out(alu_a[0]),
        .ALU_B_Out(alu_b[0]), .ALU_Result_In(alu_result[0]), .ALU_Carry_In(alu_carry[0]),
        .Rsp_Valid_Out(rsp_valid[0]), .Rsp_Ready_In(rsp_ready[0]),
        .Rsp_Result_Out(rsp_result[0]), .Rsp_Carry_Out(rsp_carry[0]),
        .Rsp_Zero_Out(rsp_zero[0]), .Rsp_Div_Zero_Out(rsp_dz[0])
    );

    alu_op_sequencer #(.SETTLE_CYCLES(4)) dut_s4 (
        .Clock_In(clock), .Reset_In(reset),
        .Cmd_Valid_In(cmd_valid[1]), .Cmd_Ready_Out(cmd_ready[1]), .Cmd_Op_In(cmd_op[1]),
        .Cmd_Use_Acc_In(cmd_use_acc[1]), .Cmd_A_In(cmd_a[1]), .Cmd_B_In(cmd_b[1]),
        .ALU_Enable_Out(alu_en[1]), .ALU_Op_Out(alu_op[1]), .ALU_A_Out(alu_a[1]),
        .ALU_B_Out(alu_b[1]), .ALU_Result_In(alu_result[1]), .ALU_Carry_In(alu_carry[1]),
        .Rsp_Valid_Out(rsp_valid[1]), .Rsp_Ready_In(rsp_ready[1]),
        .Rsp_Result_Out(rsp_result[1]), .Rsp_Carry_Out(rsp_carry[1]),
        .Rsp_Zero_Out(rsp_zero[1]), .Rsp_Div_Zero_Out(rsp_dz[1])
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    task automatic checkResetValues(input int idx);
        checkOutput("reset_flags",
                    {26'h0, cmd_ready[idx], rsp_valid[idx], alu_en[idx],
                     rsp_carry[idx], rsp_zero[idx], rsp_dz[idx]}, 32'b100010);
        checkOutput("reset_alu_op_a", {12'h0, alu_op[idx], alu_a[idx]}, 32'h0);
        checkOutput("reset_alu_b", {16'h0, alu_b[idx]}, 32'h0);
        checkOutput("reset_rsp_result", {16'h0, rsp_result[idx]}, 32'h0);
    endtask

    // One full command/response transaction with the command held busy-asserted
    // (random junk) so any acceptance outside IDLE shows up.
    task automatic applyStimulus(input int idx, input logic [3:0] op, input logic use_acc,
                                 input logic [15:0] a, input logic [15:0] b, input int hold);
        logic [15:0] a_eff, exp_res;
        logic [16:0] full;
        logic dz, exp_carry, ops_ok, stable_ok;
        int lat, en_cnt, first_en, s;
        s         = settle_of(idx);
        a_eff     = use_acc ? acc_model[idx] : a;
        dz        = ((op == 4'h6) || (op == 4'h7)) && (b == 16'h0);
        full      = alu_full(op, a_eff, b);
        exp_res   = dz ? 16'h0 : full[15:0];
        exp_carry = dz ? 1'b0 : (op[3] ? 1'b0 : full[16]);

        @(negedge clock);
        checkOutput("cmd_ready_idle", {31'h0, cmd_ready[idx]}, 32'h1);
        cmd_valid[idx]   = 1'b1;
        cmd_op[idx]      = op;
        cmd_use_acc[idx] = use_acc;
        cmd_a[idx]       = a;
        cmd_b[idx]       = b;
        @(posedge clock);
        #1;
        cmd_op[idx]      = 4'($urandom);
        cmd_use_acc[idx] = 1'($urandom);
        cmd_a[idx]       = 16'($urandom);
        cmd_b[idx]       = 16'($urandom);

        lat      = 0;
        en_cnt   = 0;
        first_en = -1;
        ops_ok   = 1'b1;
        while (rsp_valid[idx] !== 1'b1 && lat < 40) begin
            if (alu_en[idx] === 1'b1) begin
                en_cnt++;
                if (first_en < 0) first_en = lat;
            end
            if (alu_op[idx] !== op || alu_a[idx] !== a_eff || alu_b[idx] !== b) ops_ok = 1'b0;
            @(posedge clock);
            #1;
            lat++;
        end
        checkOutput("rsp_latency", 32'(lat), dz ? 32'd1 : 32'(s + 1));
        checkOutput("enable_cycles", 32'(en_cnt), dz ? 32'd0 : 32'(s));
        if (!dz) checkOutput("enable_first", 32'(first_en), 32'd1);
        checkOutput("alu_operands", {31'h0, ops_ok}, 32'h1);
        checkOutput("enable_in_resp", {31'h0, alu_en[idx]}, 32'h0);
        checkOutput("rsp_result", {16'h0, rsp_result[idx]}, {16'h0, exp_res});
        checkOutput("rsp_flags", {29'h0, rsp_carry[idx], rsp_zero[idx], rsp_dz[idx]},
                    {29'h0, exp_carry, exp_res == 16'h0, dz});

        stable_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            #1;
            if (rsp_valid[idx] !== 1'b1 || cmd_ready[idx] !== 1'b0 ||
                rsp_result[idx] !== exp_res || rsp_carry[idx] !== exp_carry ||
                rsp_dz[idx] !== dz) stable_ok = 1'b0;
        end
        checkOutput("rsp_hold", {31'h0, stable_ok}, 32'h1);

        rsp_ready[idx] = 1'b1;
        @(posedge clock);
        #1;
        rsp_ready[idx] = 1'b0;
        cmd_valid[idx] = 1'b0;
        checkOutput("after_rsp_hs", {30'h0, cmd_ready[idx], rsp_valid[idx]}, 32'b10);
        if (!dz) acc_model[idx] = full[15:0];
    endtask

    initial begin
        logic [15:0] b_rand;
        logic quiet_ok;
        int idx;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cmd_valid[i]   = 1'b0;
            cmd_op[i]      = 4'h0;
            cmd_use_acc[i] = 1'b0;
            cmd_a[i]       = 16'h0;
            cmd_b[i]       = 16'h0;
            rsp_ready[i]   = 1'b0;
            acc_model[i]   = 16'h0;
        end
        #1;
        checkResetValues(0);
        checkResetValues(1);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        applyStimulus(0, 4'h2, 1'b0, 16'h0005, 16'h0003, 0);
        applyStimulus(0, 4'h0, 1'b0, 16'hFFFF, 16'h1111, 1);
        applyStimulus(0, 4'h0, 1'b1, 16'h5A5A, 16'h0000, 0);
        applyStimulus(0, 4'h6, 1'b0, 16'h1234, 16'h0000, 10);
        applyStimulus(0, 4'h0, 1'b1, 16'h0BAD, 16'h0000, 0);
        applyStimulus(1, 4'hA, 1'b0, 16'h00FF, 16'h0000, 10);
        applyStimulus(1, 4'h7, 1'b1, 16'h0000, 16'h0000, 2);

        for (int n = 0; n < 40; n++) begin
            idx    = int'($urandom_range(0, 1));
            b_rand = 16'($urandom);
            if ($urandom_range(0, 3) == 0) b_rand = 16'h0;
            applyStimulus(idx, 4'($urandom), 1'($urandom), 16'($urandom), b_rand,
                          int'($urandom_range(0, 3)));
        end

        // Reset in the second DRIVE cycle of a multiply on the settle-4 sequencer.
        @(negedge clock);
        cmd_valid[1] = 1'b1;
        cmd_op[1]    = 4'h5;
        cmd_use_acc[1] = 1'b0;
        cmd_a[1]     = 16'h0100;
        cmd_b[1]     = 16'h0100;
        @(posedge clock);
        #1;
        cmd_valid[1] = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("enable_before_reset", {31'h0, alu_en[1]}, 32'h1);
        reset = 1'b1;
        #1;
        checkResetValues(1);
        @(negedge clock);
        reset = 1'b0;
        acc_model[0] = 16'h0;
        acc_model[1] = 16'h0;
        quiet_ok = 1'b1;
        repeat (12) begin
            @(posedge clock);
            #1;
            if (rsp_valid[1] !== 1'b0 || alu_en[1] !== 1'b0) quiet_ok = 1'b0;
        end
        checkOutput("no_rsp_after_reset", {31'h0, quiet_ok}, 32'h1);
        applyStimulus(1, 4'h0, 1'b1, 16'($urandom), 16'($urandom), 0);
        applyStimulus(0, 4'h0, 1'b1, 16'($urandom), 16'($urandom), 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Command sequencer that sits directly upstream of the 16-bit combinational ALU. It accepts one operation per valid/ready handshake, drives the ALU's enable, opcode and operand inputs for a programmable settle time, and captures the 17-bit result. It returns the result with status flags over a second valid/ready handshake. It also holds an accumulator so chained operations can reuse the previous result as operand A.

## Interface
- SETTLE_CYCLES, 1: cycles ALU inputs are held with enable high before capture; legal 1..15
- Clock_In  input  1  single clock, rising edge
- Reset_In  input  1  asynchronous, active-high reset
- Cmd_Valid_In  input  1  command present
- Cmd_Ready_Out  output  1  sequencer can accept a command
- Cmd_Op_In  input  4  ALU opcode: 0 A+1, 1 A-1, 2 A+B, 3 A-B, 4 B-A, 5 A*B, 6 A/B, 7 A%B, 8 AND, 9 OR, A ~A, B ~B, C NAND, D NOR, E XOR, F XNOR
- Cmd_Use_Acc_In  input  1  replace operand A with the accumulator
- Cmd_A_In  input  16  operand A
- Cmd_B_In  input  16  operand B
- ALU_Enable_Out  output  1  ALU enable
- ALU_Op_Out  output  4  ALU opcode
- ALU_A_Out  output  16  ALU operand A
- ALU_B_Out  output  16  ALU operand B
- ALU_Result_In  input  16  ALU result
- ALU_Carry_In  input  1  ALU carry / bit 16
- Rsp_Valid_Out  output  1  response present
- Rsp_Ready_In  input  1  consumer accepts response
- Rsp_Result_Out  output  16  captured result
- Rsp_Carry_Out  output  1  captured carry; forced 0 for opcodes 8..F
- Rsp_Zero_Out  output  1  Rsp_Result_Out == 0
- Rsp_Div_Zero_Out  output  1  opcode 6 or 7 issued with effective B == 0

## Operation
- The FSM has three states: IDLE, DRIVE and RESP. Cmd_Ready_Out = (state == IDLE). Commands are never overlapped.
- In IDLE, Cmd_Valid_In & Cmd_Ready_Out is a handshake. It registers the opcode, effective A (the accumulator if Cmd_Use_Acc_In, else Cmd_A_In) and B.
- On a normal handshake the FSM moves to DRIVE and loads the settle counter with SETTLE_CYCLES-1.
- Division by zero (opcode 6 or 7 with B == 0):
  - The FSM goes directly to RESP and the ALU is never enabled.
  - The response is Result 0, Carry 0, Zero 1, Div_Zero 1.
  - The accumulator is unchanged.
- In DRIVE, ALU_Enable_Out = 1 and the counter decrements each cycle.
- When the counter reaches 0, the FSM captures ALU_Result_In and ALU_Carry_In, masking the carry to 0 for opcodes 8..F. It then goes to RESP.
- On a capture in DRIVE, the accumulator is loaded with the 16-bit result.
- In RESP, Rsp_Valid_Out = 1 and the response outputs hold stable. When Rsp_Ready_In is high, the FSM returns to IDLE.
- Rsp_Ready_In is ignored outside RESP. Cmd_* inputs are ignored outside IDLE.
- ALU_Op_Out, ALU_A_Out and ALU_B_Out always reflect the registered operands. Only ALU_Enable_Out gates the ALU.
- All arithmetic is unsigned. The accumulator is 16 bits and reset to 0. No sign or overflow flag is produced.

## Timing
- Reset values:
  - Cmd_Ready_Out = 1 (state IDLE).
  - Rsp_Valid_Out, ALU_Enable_Out, Rsp_Carry_Out and Rsp_Div_Zero_Out = 0.
  - Rsp_Zero_Out = 1.
  - ALU_Op/A/B_Out, Rsp_Result_Out and the accumulator = 0.
- For a command handshake at edge T:
  - ALU_Enable_Out is high for exactly SETTLE_CYCLES cycles, from T+1.
  - Rsp_Valid_Out rises after edge T+SETTLE_CYCLES+1. Latency is SETTLE_CYCLES+1 cycles.
- For a div-zero command, Rsp_Valid_Out rises after edge T+1.
- A response handshake at edge R makes Cmd_Ready_Out high after R. The earliest next command is at edge R+1.
- Peak throughput is one command per SETTLE_CYCLES+3 cycles.
- Asserting Reset_In mid-DRIVE or mid-RESP immediately forces all outputs to their reset values. The in-flight command and its response are discarded.
- All outputs are registered except Cmd_Ready_Out and Rsp_Valid_Out, which are decoded directly from the state register.

## Structure
- Shared package alu_pkg holds:
  - the 16 opcode localparams (OP_A_INC .. OP_XNOR);
  - the FSM state encoding (ST_IDLE, ST_DRIVE, ST_RESP);
  - the data width constant 16.
- The sequencer is a single module with no sub-modules. The ALU is instantiated alongside it by the parent, connected through the ALU_* ports.

## Test plan
- SETTLE_CYCLES=1: A=0x0005, B=0x0003, op 2 -> enable high for 1 cycle; response Result 0x0008, Carry 0, Zero 0, 2 cycles after accept.
- Op 0 with A=0xFFFF -> Result 0x0000, Carry 1, Zero 1. The next command, op 0 with Use_Acc=1, gives Result 0x0001.
- Op 6 with A=0x1234, B=0 -> ALU_Enable_Out never rises; response 1 cycle after accept with Result 0, Div_Zero 1; accumulator unchanged.
- Op 0xA with A=0x00FF, SETTLE_CYCLES=4 -> enable high for 4 cycles; Result 0xFF00, Carry masked to 0.
- Rsp_Ready_In held low for 10 cycles after Rsp_Valid_Out -> response stable and Cmd_Ready_Out low throughout; a new command presented meanwhile is not accepted until after the response handshake.
- Reset_In pulsed in the second DRIVE cycle of op 5 (0x0100 * 0x0100) -> all outputs at reset values immediately; no response ever issued; accumulator 0.
